pwm_decoder: RTL and testbench
==============================

PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter SD, default 39: clock cycles of high time per duty step.
REQ-002 SHALL have parameter PERIOD_NOM, default 10000: nominal PWM period in clock cycles.
REQ-003 SHALL have parameter PERIOD_TOL, default 100: allowed +/- deviation of the measured period.
REQ-004 SHALL have parameter TIMEOUT, default 12000: cycles without a rising edge before signal loss is declared.
REQ-005 SHALL have port clk, input, 1 bit: clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port pwm_in, input, 1 bit: asynchronous PWM waveform to decode.
REQ-008 SHALL have port duty_out, output, 8 bits: last decoded duty step.
REQ-009 SHALL have port duty_valid, output, 1 bit: one-cycle strobe when duty_out updates.
REQ-010 SHALL have port period_err, output, 1 bit: one-cycle strobe when a period is out of tolerance.
REQ-011 SHALL have port signal_lost, output, 1 bit: level, high while no valid PWM is tracked.

Function
REQ-012 SHALL pass pwm_in through two synchronizer flops (s1, s2) plus one delay flop (s3); rise = s2 & ~s3.
REQ-013 SHALL run a main FSM with states ACQUIRE and MEASURE.
REQ-014 In ACQUIRE, SHALL ignore levels until rise, then load period_cnt=1, high_cnt=1 and enter MEASURE; no strobes.
REQ-015 In MEASURE, SHALL increment period_cnt every cycle and high_cnt every cycle s2=1 (14-bit counters).
REQ-016 On rise in MEASURE, SHALL capture period_cnt and high_cnt, then reload both counters to 1 in the same edge.
REQ-017 If the captured period is within [PERIOD_NOM-PERIOD_TOL, PERIOD_NOM+PERIOD_TOL], SHALL start the divider with the captured high_cnt.
REQ-018 If the captured period is outside the tolerance, SHALL pulse period_err for one cycle the cycle after capture, start no divide, and leave duty_out unchanged.
REQ-019 Divider SHALL be a separate FSM, DIV_IDLE/DIV_RUN, computing q = floor((high + SD/2) / SD) by 15-iteration restoring division, one quotient bit per clock.
REQ-020 SHALL saturate q to 255 and register it to duty_out with duty_valid=1 exactly 16 clocks after the capture edge.
REQ-021 If a rise occurs while the divider is in DIV_RUN, SHALL restart the counters, pulse period_err, keep the in-flight divide operand unchanged, and still deliver the in-flight result.
REQ-022 If period_cnt reaches TIMEOUT in MEASURE without a rise, SHALL set duty_out = 0 when s2=0 or 255 when s2=1, pulse duty_valid, set signal_lost=1, and return to ACQUIRE.
REQ-023 SHALL hold period_cnt at TIMEOUT, with no wrap, until the state change.
REQ-024 SHALL clear signal_lost on the first in-tolerance duty_valid after ACQUIRE.
REQ-025 When timeout and divider completion coincide, SHALL let the timeout value win and drop the divide result.
REQ-026 SHALL hold duty_out stable between duty_valid strobes.

Reset
REQ-027 On reset, SHALL force duty_out=0, duty_valid=0, period_err=0, signal_lost=1, s1/s2/s3=0, counters=0, main FSM=ACQUIRE and divider=DIV_IDLE.
REQ-028 Reset mid-divide SHALL abort the divide with no duty_valid pulse.
REQ-029 Reset SHALL take precedence over all other events in the same cycle.

Verification
REQ-030 Period 10000 with high 3900 for 3 periods -> duty_out=100, duty_valid pulses at 16 clocks after each captured rise from the 2nd rise on, signal_lost=0.
REQ-031 High 39 -> duty_out=1; high 9945 -> 255; high 3919 -> 100; high 3920 -> 101.
REQ-032 Constant low for 12000+ cycles after lock -> duty_out=0, one duty_valid, signal_lost=1; constant high -> duty_out=255.
REQ-033 Period 5000 with high 1950 -> period_err pulse 1 cycle after capture, no duty_valid, duty_out unchanged.
REQ-034 Reset asserted 5 cycles after capture -> no duty_valid, duty_out=0, signal_lost=1; the next two valid periods relock.
REQ-035 Rise injected 8 cycles after a valid capture -> period_err pulse and in-flight duty_valid still delivered at +16.

Source files
------------

// File: rtl/pwm_decoder.sv
// Purpose : decode a free-running PWM waveform into an 8-bit duty step (high time / SD, rounded).
// Latency : duty_valid 16 clk after the capturing rising edge (2-flop sync + edge flop ahead of that).
// Backpress: none; the input is a free-running waveform, and results overwrite duty_out on each strobe.
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   pwm_in       - asynchronous PWM input
//   duty_out     - last decoded duty step, held between strobes
//   duty_valid   - one-cycle strobe when duty_out updates
//   period_err   - one-cycle strobe when a captured period is rejected
//   signal_lost  - high while no valid PWM is being tracked
module pwm_decoder #(
    parameter int SD         = 39,
    parameter int PERIOD_NOM = 10000,
    parameter int PERIOD_TOL = 100,
    parameter int TIMEOUT    = 12000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [7:0] duty_out,
    output logic       duty_valid,
    output logic       period_err,
    output logic       signal_lost
);

    localparam logic [13:0] P_MIN   = 14'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [13:0] P_MAX   = 14'(PERIOD_NOM + PERIOD_TOL);
    localparam logic [13:0] T_MAX   = 14'(TIMEOUT);
    localparam logic [14:0] HALF_SD = 15'(SD / 2);
    localparam logic [15:0] DIVISOR = 16'(SD);

    typedef enum logic {ACQUIRE, MEASURE} main_state_t;
    typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

    main_state_t main_state;
    div_state_t  div_state;

    logic        s1, s2, s3;
    logic        rise;
    logic [13:0] period_cnt;
    logic [13:0] high_cnt;

    logic [14:0] div_num;   // dividend bits shift out the top, quotient bits shift in at the bottom
    logic [14:0] div_rem;
    logic [3:0]  div_iter;

    logic        in_tol;
    logic        div_start;
    logic        div_done;
    logic        timeout_evt;
    logic [15:0] rem_shift;
    logic        rem_ge;
    logic [14:0] rem_next;
    logic [7:0]  quot_sat;

    assign rise        = s2 & ~s3;
    assign in_tol      = (period_cnt >= P_MIN) && (period_cnt <= P_MAX);
    assign div_start   = (main_state == MEASURE) && rise && in_tol && (div_state == DIV_IDLE);
    assign timeout_evt = (main_state == MEASURE) && !rise && (period_cnt >= T_MAX);
    // 15 iterations occupy iter 0..14; the 16th cycle in DIV_RUN hands the result over.
    assign div_done    = (div_state == DIV_RUN) && (div_iter == 4'd15);

    // One restoring-division step. The remainder stays below SD, so once the
    // trial subtraction succeeds the result fits back into 15 bits.
    assign rem_shift = {div_rem, div_num[14]};
    assign rem_ge    = (rem_shift >= DIVISOR);
    assign rem_next  = rem_ge ? 15'(rem_shift - DIVISOR) : rem_shift[14:0];
    assign quot_sat  = (|div_num[14:8]) ? 8'hFF : div_num[7:0];

    // Synchronizer, measurement FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            main_state  <= ACQUIRE;
            duty_out    <= 8'd0;
            duty_valid  <= 1'b0;
            period_err  <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            s1         <= pwm_in;
            s2         <= s1;
            s3         <= s2;
            duty_valid <= 1'b0;
            period_err <= 1'b0;

            case (main_state)
                ACQUIRE: begin
                    if (rise) begin
                        period_cnt <= 14'd1;
                        high_cnt   <= 14'd1;
                        main_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // The counters themselves are the captured values; the
                        // divider samples high_cnt on this same edge.
                        period_cnt <= 14'd1;
                        high_cnt   <= 14'd1;
                        period_err <= !div_start;
                    end else if (period_cnt >= T_MAX) begin
                        // Counter is not advanced here, so it holds at TIMEOUT.
                        duty_out    <= s2 ? 8'hFF : 8'h00;
                        duty_valid  <= 1'b1;
                        signal_lost <= 1'b1;
                        main_state  <= ACQUIRE;
                    end else begin
                        period_cnt <= period_cnt + 14'd1;
                        high_cnt   <= high_cnt + {13'd0, s2};
                    end
                end
                default: main_state <= ACQUIRE;
            endcase

            // A coincident timeout owns duty_out; the divide result is dropped.
            if (div_done && !timeout_evt) begin
                duty_out    <= quot_sat;
                duty_valid  <= 1'b1;
                signal_lost <= 1'b0;
            end
        end
    end

    // Divider FSM: q = floor((high + SD/2) / SD), one quotient bit per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            div_num   <= '0;
            div_rem   <= '0;
            div_iter  <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        div_num   <= {1'b0, high_cnt} + HALF_SD;
                        div_rem   <= '0;
                        div_iter  <= '0;
                        div_state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (timeout_evt || div_done) begin
                        div_state <= DIV_IDLE;
                    end else begin
                        div_rem  <= rem_next;
                        div_num  <= {div_num[13:0], rem_ge};
                        div_iter <= div_iter + 4'd1;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder with shortened periods (SD=3, nominal 1000 +/- 10, timeout 1200).
// The reference model works on rise times and high widths only: each rise after lock
// measures the distance to the previous rise and yields either a duty result 16 clocks
// after capture or a period error, plus timeout and reset handling in the directed steps.
module tb_pwm_decoder;

    localparam int SD   = 3;
    localparam int NOM  = 1000;
    localparam int TOL  = 10;
    localparam int TOUT = 1200;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [7:0] duty_out;
    logic       duty_valid;
    logic       period_err;
    logic       signal_lost;

    pwm_decoder #(
        .SD(SD), .PERIOD_NOM(NOM), .PERIOD_TOL(TOL), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in),
        .duty_out(duty_out), .duty_valid(duty_valid),
        .period_err(period_err), .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // observed events
    int dv_cyc[$];
    int dv_val[$];
    int pe_cyc[$];
    int hold_bad = 0;
    logic [7:0] prev_duty = 8'd0;
    logic       rst_d = 1'b1;

    always @(negedge clk) begin
        if (duty_valid) begin
            dv_cyc.push_back(cyc);
            dv_val.push_back(int'(duty_out));
        end
        if (period_err) pe_cyc.push_back(cyc);
        if (!reset && !rst_d && !duty_valid && duty_out !== prev_duty) hold_bad++;
        prev_duty = duty_out;
        rst_d     = reset;
    end

    // reference model state
    int exp_dv_cyc[$];
    int exp_dv_val[$];
    int exp_pe_cyc[$];
    int exp_duty   = 0;
    bit locked     = 1'b0;
    int last_rise  = 0;
    int last_hi    = 0;
    int last_start = -1000;

    function automatic int exp_q(input int h);
        int q;
        q = (h + SD / 2) / SD;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Raise pwm_in now (called at a negedge) and predict what this rise produces.
    task automatic start_period(input int hi);
        int t, p;
        t = cyc;
        if (locked) begin
            p = t - last_rise;
            if (p >= NOM - TOL && p <= NOM + TOL &&
                !(t - last_start >= 1 && t - last_start <= 16)) begin
                exp_dv_cyc.push_back(t + 19);
                exp_dv_val.push_back(exp_q(last_hi));
                exp_duty   = exp_q(last_hi);
                last_start = t;
            end else begin
                exp_pe_cyc.push_back(t + 3);
            end
        end
        locked    = 1'b1;
        last_rise = t;
        last_hi   = hi;
        pwm_in    = 1'b1;
    endtask

    task automatic drive_period(input int per, input int hi);
        start_period(hi);
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic clear_events();
        dv_cyc.delete(); dv_val.delete(); pe_cyc.delete();
        exp_dv_cyc.delete(); exp_dv_val.delete(); exp_pe_cyc.delete();
    endtask

    task automatic check_events(input string sec);
        chk({sec, "_dv_count"}, dv_cyc.size(), exp_dv_cyc.size());
        chk({sec, "_err_count"}, pe_cyc.size(), exp_pe_cyc.size());
        for (int i = 0; i < dv_cyc.size() && i < exp_dv_cyc.size(); i++) begin
            chk({sec, "_dv_time"}, dv_cyc[i], exp_dv_cyc[i]);
            chk({sec, "_dv_value"}, dv_val[i], exp_dv_val[i]);
        end
        for (int i = 0; i < pe_cyc.size() && i < exp_pe_cyc.size(); i++)
            chk({sec, "_err_time"}, pe_cyc[i], exp_pe_cyc[i]);
        clear_events();
    endtask

    task automatic check_timeout(input string sec, input int expv);
        chk({sec, "_count"}, dv_cyc.size(), 1);
        if (dv_cyc.size() > 0) begin
            chk({sec, "_value"}, dv_val[0], expv);
            chk({sec, "_delay_in_window"},
                int'(dv_cyc[0] - last_rise >= TOUT && dv_cyc[0] - last_rise <= TOUT + 8), 1);
        end
        chk({sec, "_no_err"}, pe_cyc.size(), 0);
        chk({sec, "_lost"}, int'(signal_lost), 1);
        chk({sec, "_duty"}, int'(duty_out), expv);
        exp_duty = expv;
        locked   = 1'b0;
        clear_events();
    endtask

    initial begin
        int per, hi;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_duty", int'(duty_out), 0);
        chk("rst_valid", int'(duty_valid), 0);
        chk("rst_err", int'(period_err), 0);
        chk("rst_lost", int'(signal_lost), 1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // three nominal periods of 30% high plus the closing rise
        repeat (4) drive_period(1000, 300);
        check_events("nominal");
        chk("nominal_duty", int'(duty_out), 100);
        chk("nominal_lost", int'(signal_lost), 0);

        // rounding and saturation boundaries (3->1, 900->255, 301->100, 302->101)
        drive_period(1000, 3);
        drive_period(1000, 900);
        drive_period(1000, 301);
        drive_period(1000, 302);
        drive_period(1000, 300);
        check_events("bounds");
        chk("bounds_duty", int'(duty_out), 101);

        // period tolerance edges: 990 and 1010 accepted, 989 and 1011 rejected
        drive_period(990, 300);
        drive_period(1010, 300);
        drive_period(989, 300);
        drive_period(1011, 300);
        drive_period(1000, 300);
        check_events("tol");

        // half-rate period: error strobe only, duty held
        drive_period(500, 195);
        drive_period(1000, 300);
        chk("halfrate_duty_held", int'(duty_out), exp_duty);
        check_events("halfrate");
        drive_period(1000, 300);
        check_events("halfrate_relock");

        // extra rise 8 cycles after a valid capture
        drive_period(8, 5);
        drive_period(1000, 300);
        drive_period(1000, 300);
        check_events("inject");
        chk("inject_duty", int'(duty_out), exp_duty);

        // randomized periods around nominal
        for (int i = 0; i < 12; i++) begin
            per = NOM - 3 * TOL + int'($urandom_range(6 * TOL));
            hi  = 1 + int'($urandom_range(per - 2));
            drive_period(per, hi);
        end
        check_events("random");
        chk("random_duty", int'(duty_out), exp_duty);

        // constant low after lock
        repeat (TOUT + 40) @(negedge clk);
        check_timeout("timeout_low", 0);

        // relock, then constant high
        drive_period(1000, 300);
        start_period(TOUT + 200);
        repeat (30) @(negedge clk);
        check_events("pre_high");
        chk("pre_high_lost", int'(signal_lost), 0);
        repeat (TOUT + 30) @(negedge clk);
        check_timeout("timeout_high", 255);
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);

        // reset 5 cycles after a valid capture aborts the divide
        drive_period(1000, 300);
        drive_period(1000, 300);
        check_events("pre_reset");
        start_period(3);
        repeat (3) @(negedge clk);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        void'(exp_dv_cyc.pop_back());
        void'(exp_dv_val.pop_back());
        exp_duty = 0;
        locked   = 1'b0;
        repeat (40) @(negedge clk);
        check_events("reset_abort");
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_lost", int'(signal_lost), 1);
        drive_period(1000, 300);
        drive_period(1000, 300);
        check_events("reset_relock");
        chk("relock_duty", int'(duty_out), 100);
        chk("relock_lost", int'(signal_lost), 0);

        chk("duty_held_between_strobes", hold_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
